// File: rtl/divider_pkg.sv
// Shared arithmetic-block definitions: state encoding, default width, counter sizing.
// Pure declarations; no latency, no handshake.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 64;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/divider_if.sv
// op_start/op_clear/op_done handshake and operand/result buses of the divider.
// master = controller side, slave = divider side; no flow control beyond op_done.
interface divider_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             op_start;
  logic             op_clear;
  logic             op_done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output dividend, divisor, op_start, op_clear,
    input  op_done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  dividend, divisor, op_start, op_clear,
    output op_done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/divider_step.sv
// One combinational restoring-division step: trial-subtract D from {R, q_msb}.
// Zero latency, no handshake.
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_r_next,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_trial;

  assign w_trial  = {i_r, i_q_msb} - {1'b0, i_d};
  assign o_q_bit  = ~w_trial[WIDTH];
  // Negative trial restores the shifted partial remainder.
  assign o_r_next = w_trial[WIDTH] ? {i_r[WIDTH-2:0], i_q_msb} : w_trial[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock; op_done WIDTH edges after start.
// op_start ignored outside IDLE; result held in DONE until op_clear or reset.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic      clk,
  input logic      reset_n,
  divider_if.slave bus
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_dbz;

  logic [WIDTH-1:0] w_r_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q_next;
  logic             w_load;
  logic             w_last;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .i_r      (r_rem),
    .i_q_msb  (r_quo[WIDTH-1]),
    .i_d      (r_div),
    .o_r_next (w_r_next),
    .o_q_bit  (w_q_bit)
  );

  assign w_q_next = {r_quo[WIDTH-2:0], w_q_bit};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_last = 1'b0;
    if (bus.op_clear) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (bus.op_start) begin
          w_next = EXEC;
          w_load = 1'b1;
        end
        EXEC: if (r_cnt == LAST) begin
          w_next = DONE;
          w_last = 1'b1;
        end
        DONE:    w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
    end else if (bus.op_clear) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
    end else if (w_load) begin
      r_rem <= '0;
      r_quo <= bus.dividend;
      r_div <= bus.divisor;
      r_cnt <= '0;
    end else if (r_state == EXEC) begin
      r_rem <= w_r_next;
      r_quo <= w_q_next;
      r_cnt <= r_cnt + CW'(1);
      // Results become visible only with the final step, never partially.
      if (w_last) begin
        r_done  <= 1'b1;
        r_q_out <= w_q_next;
        r_r_out <= w_r_next;
        r_dbz   <= (r_div == '0);
      end
    end
  end

  assign bus.op_done     = r_done;
  assign bus.quotient    = r_q_out;
  assign bus.remainder   = r_r_out;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider.sv
// Directed + random checks of divider (WIDTH=64) against a plain '/' and '%' reference.
module tb_divider;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  divider_if #(.WIDTH(64)) bus ();

  divider #(.WIDTH(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r);
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_done"}, {63'd0, bus.op_done}, 64'd0);
    check({tag, "_q"}, bus.quotient, 64'd0);
    check({tag, "_r"}, bus.remainder, 64'd0);
    check({tag, "_dbz"}, {63'd0, bus.div_by_zero}, 64'd0);
  endtask

  task automatic do_clear();
    bus.op_start = 1'b0;
    bus.op_clear = 1'b1;
    tick();
    bus.op_clear = 1'b0;
    check("clear_done", {63'd0, bus.op_done}, 64'd0);
    check("clear_q", bus.quotient, 64'd0);
  endtask

  // Start one division, scramble the operand inputs, and check latency and results.
  task automatic run_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input bit hold);
    logic [63:0] eq, er;
    int          cyc;
    bit          leak;
    model(a, b, eq, er);
    bus.dividend = a;
    bus.divisor  = b;
    bus.op_start = 1'b1;
    tick();
    if (!hold) bus.op_start = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = b ^ 64'h5;
    cyc  = 0;
    leak = 1'b0;
    while (cyc < 200) begin
      tick();
      cyc++;
      if (bus.op_done) break;
      if (bus.quotient != 0 || bus.remainder != 0 || bus.div_by_zero) leak = 1'b1;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd64);
    check({tag, "_partial"}, {63'd0, leak}, 64'd0);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    check({tag, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, (b == 64'd0)});
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.op_done || bus.quotient != 0 || bus.remainder != 0) seen = 1'b1;
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    logic [63:0] a, b, hq, hr;
    n_tests      = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.op_start = 1'b0;
    bus.op_clear = 1'b0;
    repeat (3) tick();
    check_zero_outputs("reset");
    reset_n = 1'b1;
    tick();

    run_div("basic", 64'h784b, 64'h0101, 1'b0);
    do_clear();
    run_div("inverse", 64'h78C34B, 64'h0101, 1'b0);
    do_clear();
    run_div("max_by_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    do_clear();
    run_div("small", 64'd5, 64'd7, 1'b0);
    do_clear();
    run_div("div0", 64'h1234, 64'd0, 1'b0);
    do_clear();

    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      case (i % 4)
        0:       b = {$urandom, $urandom};
        1:       b = 64'($urandom_range(1, 1000));
        2:       b = {32'd0, $urandom};
        default: b = (i == 7) ? 64'd0 : a >> $urandom_range(1, 40);
      endcase
      run_div("rand", a, b, 1'b0);
      do_clear();
    end

    // Abort mid-EXEC, then restart.
    bus.dividend = 64'hDEAD_BEEF_0000_1234;
    bus.divisor  = 64'h77;
    bus.op_start = 1'b1;
    tick();
    bus.op_start = 1'b0;
    repeat (20) tick();
    do_clear();
    expect_idle("abort_no_done", 70);
    run_div("restart", 64'hDEAD_BEEF_0000_1234, 64'h77, 1'b0);
    do_clear();

    // Clear and start together: no operation starts.
    bus.dividend = 64'd100;
    bus.divisor  = 64'd3;
    bus.op_start = 1'b1;
    bus.op_clear = 1'b1;
    tick();
    bus.op_start = 1'b0;
    bus.op_clear = 1'b0;
    expect_idle("clr_start_idle", 70);

    // Asynchronous reset mid-EXEC.
    bus.dividend = 64'h1_0000_0000;
    bus.divisor  = 64'd9;
    bus.op_start = 1'b1;
    tick();
    bus.op_start = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    repeat (2) tick();
    reset_n = 1'b1;
    expect_idle("post_rst_idle", 70);

    // op_start held through DONE with changing operands: results frozen.
    run_div("hold", 64'h0123_4567_89AB_CDEF, 64'h1_0001, 1'b1);
    model(64'h0123_4567_89AB_CDEF, 64'h1_0001, hq, hr);
    for (int i = 0; i < 8; i++) begin
      bus.dividend = {$urandom, $urandom};
      bus.divisor  = {$urandom, $urandom};
      tick();
    end
    check("hold_done", {63'd0, bus.op_done}, 64'd1);
    check("hold_q", bus.quotient, hq);
    check("hold_r", bus.remainder, hr);
    do_clear();
    check_zero_outputs("after_hold_clear");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
